// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: parameter defaults,
// the queue entry layout and a small address helper.
package fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC        = 32'hbfc00000;
  localparam int          DEF_QUEUE_DEPTH     = 4;
  localparam int          DEF_MAX_OUTSTANDING = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fetchEntry_t;

  function automatic logic isMisaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush and a registered head word.
// The head reads as zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           pushData,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr, wrPtr, rdNext, wrNext, wrAddr;
  logic [CW-1:0]    countReg, countNext, remain;
  logic [WIDTH-1:0] headReg, headNext;
  logic             doPush, doPop;

  // A flush may coincide with a push: the pushed word becomes the only entry.
  always_comb begin
    doPush    = push & (flush | (countReg != CW'(DEPTH)));
    doPop     = pop & ~flush & (countReg != '0);
    remain    = countReg - CW'(doPop);
    wrAddr    = flush ? '0 : wrPtr;
    rdNext    = flush ? '0 : rdPtr + AW'(doPop);
    wrNext    = wrAddr + AW'(doPush);
    countNext = (flush ? '0 : remain) + CW'(doPush);
    if (countNext == '0) begin
      headNext = '0;
    end else if (flush || remain == '0) begin
      headNext = pushData;
    end else begin
      headNext = mem[rdNext];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      countReg <= '0;
      headReg  <= '0;
    end else begin
      rdPtr    <= rdNext;
      wrPtr    <= wrNext;
      countReg <= countNext;
      headReg  <= headNext;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && doPush) begin
      mem[wrAddr] <= pushData;
    end
  end

  assign count = countReg;
  assign head  = headReg;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: sequential PC generation, credit-limited request issue,
// in-order response tracking with stale-response discard, and the decode queue.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEF_RESET_PC,
  parameter int          QUEUE_DEPTH     = DEF_QUEUE_DEPTH,
  parameter int          MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        readyD,
  output logic        validD,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        adelD
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int EW = $bits(fetchEntry_t);

  logic [31:0]   fetchPc, respPc;
  logic [OW-1:0] outstanding, discard, outsAfterResp;
  logic          halted;
  logic [CW-1:0] fifoCount;
  logic          fifoPush, fifoPop;
  logic [EW-1:0] headBits;
  fetchEntry_t   pushEntry, headEntry;
  logic          accept, keepResp, misaligned;

  assign misaligned    = isMisaligned(redirect_pc);
  assign accept        = inst_req & inst_addr_ok;
  assign keepResp      = inst_data_ok & (discard == '0);
  assign outsAfterResp = outstanding - OW'(inst_data_ok);

  // Every in-flight request already owns a queue slot, so the FIFO cannot overflow.
  assign inst_req  = resetn & ~redirect & ~halted
                   & (32'(outstanding) < MAX_OUTSTANDING)
                   & (32'(outstanding) + 32'(fifoCount) < QUEUE_DEPTH);
  assign inst_addr = fetchPc;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      halted      <= 1'b0;
    end else if (redirect) begin
      fetchPc     <= redirect_pc;
      respPc      <= redirect_pc;
      outstanding <= outsAfterResp;
      discard     <= outsAfterResp;
      halted      <= misaligned;
    end else begin
      if (accept) begin
        fetchPc <= fetchPc + 32'd4;
      end
      if (keepResp) begin
        respPc <= respPc + 32'd4;
      end
      outstanding <= outsAfterResp + OW'(accept);
      if (inst_data_ok && discard != '0) begin
        discard <= discard - OW'(1);
      end
    end
  end

  always_comb begin
    pushEntry = '0;
    if (redirect) begin
      pushEntry.pc   = redirect_pc;
      pushEntry.adel = 1'b1;
    end else begin
      pushEntry.pc    = respPc;
      pushEntry.instr = inst_rdata;
    end
  end

  assign fifoPush = resetn & (redirect ? misaligned : keepResp);
  assign fifoPop  = validD & readyD & ~redirect;

  sync_fifo #(
    .WIDTH(EW),
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .resetn  (resetn),
    .push    (fifoPush),
    .pop     (fifoPop),
    .flush   (redirect),
    .pushData(pushEntry),
    .count   (fifoCount),
    .head    (headBits)
  );

  assign headEntry = fetchEntry_t'(headBits);
  assign validD    = fifoCount != '0;
  assign instrD    = headEntry.instr;
  assign pcD       = headEntry.pc;
  assign adelD     = headEntry.adel;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: a vector table, directed corner-case sequences,
// and a randomized run against an epoch-tagged queue model.
module tb_inst_fetch_queue;
  logic clk = 1'b0;
  logic resetn, inst_req, inst_addr_ok, inst_data_ok, redirect, readyD, validD, adelD;
  logic [31:0] inst_addr, inst_rdata, redirect_pc, instrD, pcD;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_queue dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .readyD(readyD), .validD(validD), .instrD(instrD), .pcD(pcD), .adelD(adelD)
  );

  localparam logic [31:0] RPC = 32'hbfc00000;

  typedef struct {
    logic rstn, aok, dok;
    logic [31:0] rdata;
    logic rdy;
    logic eReq;
    logic [31:0] eAddr;
    logic eValid;
    logic [31:0] eInstr, ePc;
  } vec_t;

  typedef struct {logic [31:0] addr; int epoch;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr; logic adel;} ent_t;

  vec_t  vecs[12];
  pend_t pend[$];
  ent_t  mq[$];
  logic [31:0] mPc;
  logic  mHalt;
  int    epoch;

  function automatic vec_t mkVec(input logic rstn, aok, dok, input logic [31:0] rdata,
                                 input logic rdy, eReq, input logic [31:0] eAddr,
                                 input logic eValid, input logic [31:0] eInstr, ePc);
    vec_t v;
    v.rstn = rstn; v.aok = aok; v.dok = dok; v.rdata = rdata; v.rdy = rdy;
    v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.eInstr = eInstr; v.ePc = ePc;
    return v;
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h0badf00d;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chkHead(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] instr, input logic adel);
    chk1({tag, " validD"}, validD, v);
    chk32({tag, " pcD"}, pcD, pc);
    chk32({tag, " instrD"}, instrD, instr);
    chk1({tag, " adelD"}, adelD, adel);
  endtask

  // Apply one cycle of inputs and stop at the falling edge for sampling.
  task automatic drive(input logic aok, dok, input logic [31:0] rd, input logic rdy, redir,
                       input logic [31:0] rpc);
    resetn = 1'b1; inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
    readyD = rdy; redirect = redir; redirect_pc = rpc;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; readyD = 1'b0;
    advance();
    advance();

    // Reset state, first fetch, fill to the credit limit, then drain.
    vecs[0]  = mkVec(0, 0, 0, 32'h0,        0, 0, RPC,          0, 32'h0,        32'h0);
    vecs[1]  = mkVec(1, 1, 0, 32'h0,        0, 1, RPC,          0, 32'h0,        32'h0);
    vecs[2]  = mkVec(1, 1, 1, 32'h24020001, 0, 1, 32'hbfc00004, 0, 32'h0,        32'h0);
    vecs[3]  = mkVec(1, 1, 1, 32'h24030002, 0, 1, 32'hbfc00008, 1, 32'h24020001, RPC);
    vecs[4]  = mkVec(1, 1, 1, 32'h24040003, 0, 1, 32'hbfc0000c, 1, 32'h24020001, RPC);
    vecs[5]  = mkVec(1, 1, 1, 32'h24050004, 0, 0, 32'hbfc00010, 1, 32'h24020001, RPC);
    vecs[6]  = mkVec(1, 1, 0, 32'h0,        0, 0, 32'hbfc00010, 1, 32'h24020001, RPC);
    vecs[7]  = mkVec(1, 1, 0, 32'h0,        1, 0, 32'hbfc00010, 1, 32'h24020001, RPC);
    vecs[8]  = mkVec(1, 1, 0, 32'h0,        1, 1, 32'hbfc00010, 1, 32'h24030002, 32'hbfc00004);
    vecs[9]  = mkVec(1, 1, 0, 32'h0,        1, 1, 32'hbfc00014, 1, 32'h24040003, 32'hbfc00008);
    vecs[10] = mkVec(1, 0, 0, 32'h0,        1, 0, 32'hbfc00018, 1, 32'h24050004, 32'hbfc0000c);
    vecs[11] = mkVec(1, 0, 0, 32'h0,        1, 0, 32'hbfc00018, 0, 32'h0,        32'h0);
    for (int i = 0; i < 12; i++) begin
      resetn = vecs[i].rstn; inst_addr_ok = vecs[i].aok; inst_data_ok = vecs[i].dok;
      inst_rdata = vecs[i].rdata; readyD = vecs[i].rdy; redirect = 1'b0; redirect_pc = '0;
      @(negedge clk);
      chk1($sformatf("vec%0d inst_req", i), inst_req, vecs[i].eReq);
      chk32($sformatf("vec%0d inst_addr", i), inst_addr, vecs[i].eAddr);
      chkHead($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].ePc, vecs[i].eInstr, 1'b0);
      $display("vec %0d: req=%b addr=%h validD=%b pcD=%h instrD=%h", i, inst_req, inst_addr,
               validD, pcD, instrD);
      advance();
    end

    // Redirect with two requests in flight: both responses must be dropped.
    drive(1, 0, 0, 0, 1, 32'h80001000); chk1("redirA req", inst_req, 0); advance();
    drive(1, 1, 32'hdead0001, 0, 0, 0); chk1("redirA credit", inst_req, 0); advance();
    drive(1, 1, 32'hdead0002, 0, 0, 0); chk1("redirA req2", inst_req, 1);
    chk32("redirA addr", inst_addr, 32'h80001000); advance();
    drive(0, 1, 32'h11111111, 0, 0, 0); chk1("redirA dropped", validD, 0);
    chk32("redirA addr2", inst_addr, 32'h80001004); advance();
    drive(0, 0, 0, 1, 0, 0); chkHead("redirA head", 1, 32'h80001000, 32'h11111111, 0); advance();
    $display("seq redirect-with-inflight done");

    // Redirect coinciding with a response and a pop.
    drive(1, 0, 0, 0, 0, 0); chk1("redirB empty", validD, 0);
    chk32("redirB addr", inst_addr, 32'h80001004); advance();
    drive(1, 1, 32'h22222222, 0, 0, 0); chk32("redirB addr2", inst_addr, 32'h80001008); advance();
    drive(1, 0, 0, 0, 0, 0); chkHead("redirB head", 1, 32'h80001004, 32'h22222222, 0);
    chk1("redirB req3", inst_req, 1); advance();
    drive(1, 1, 32'h33333333, 1, 1, 32'h80002000); chk1("redirB req", inst_req, 0); advance();
    drive(0, 0, 0, 0, 0, 0); chk1("redirB flushed", validD, 0);
    chk32("redirB newaddr", inst_addr, 32'h80002000); advance();
    drive(0, 1, 32'h44444444, 0, 0, 0); chk1("redirB req4", inst_req, 1); advance();
    drive(1, 0, 0, 0, 0, 0); chk1("redirB stale dropped", validD, 0); advance();
    drive(0, 1, 32'h55555555, 0, 0, 0); chk1("redirB latency", validD, 0); advance();
    drive(0, 0, 0, 0, 0, 0); chkHead("redirB new head", 1, 32'h80002000, 32'h55555555, 0);
    advance();
    $display("seq redirect-with-response done");

    // Misaligned redirect: one error marker, fetch halted until the next redirect.
    drive(1, 0, 0, 0, 1, 32'hbfc00002); chk1("adel redir req", inst_req, 0); advance();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, (i == 3), 0, 0);
      chk1($sformatf("adel halt%0d", i), inst_req, 0);
      chkHead($sformatf("adel head%0d", i), 1, 32'hbfc00002, 32'h0, 1);
      advance();
    end
    drive(1, 0, 0, 0, 0, 0); chk1("adel popped", validD, 0); chk1("adel still halted", inst_req, 0);
    advance();
    drive(0, 0, 0, 0, 1, 32'hbfc00100); chk1("adel unhalt req", inst_req, 0); advance();
    $display("seq misaligned-redirect done");

    // addr_ok withheld for three cycles: request and address hold.
    for (int i = 0; i < 4; i++) begin
      drive((i == 3), 0, 0, 0, 0, 0);
      chk1($sformatf("hold%0d req", i), inst_req, 1);
      chk32($sformatf("hold%0d addr", i), inst_addr, 32'hbfc00100);
      advance();
    end
    drive(0, 0, 0, 0, 0, 0); chk32("hold advanced", inst_addr, 32'hbfc00104); advance();
    $display("seq addr-hold done");

    // Randomized run against the model, with one mid-run reset.
    pend.delete(); mq.delete(); mPc = RPC; mHalt = 1'b0; epoch = 0;
    for (int c = 0; c < 4000; c++) begin
      logic eReq;
      ent_t h;
      pend_t p;
      resetn       = !(c == 0 || c == 1 || c == 2000 || c == 2001);
      redirect     = resetn && ($urandom_range(0, 99) < (mHalt ? 20 : 4));
      redirect_pc  = 32'h80000000 | ($urandom() & 32'h000ffffc)
                   | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      inst_addr_ok = $urandom_range(0, 2) != 0;
      inst_data_ok = resetn && pend.size() > 0 && $urandom_range(0, 1) == 1;
      if (inst_data_ok) inst_rdata = memWord(pend[0].addr);
      else inst_rdata = $urandom();
      readyD = $urandom_range(0, 2) != 0;
      @(negedge clk);
      eReq = resetn && !redirect && !mHalt && pend.size() < 2 && (pend.size() + mq.size()) < 4;
      if (c > 0) begin
        chk1("rnd inst_req", inst_req, eReq);
        chk32("rnd inst_addr", inst_addr, mPc);
        if (mq.size() > 0) h = mq[0];
        else h = '{32'h0, 32'h0, 1'b0};
        chkHead("rnd", mq.size() > 0, h.pc, h.instr, h.adel);
      end
      if (!resetn) begin
        pend.delete(); mq.delete(); mPc = RPC; mHalt = 1'b0; epoch++;
      end else begin
        if (mq.size() > 0 && readyD && !redirect) void'(mq.pop_front());
        if (inst_data_ok) begin
          p = pend.pop_front();
          if (p.epoch == epoch && !redirect) mq.push_back('{p.addr, inst_rdata, 1'b0});
        end
        if (eReq && inst_addr_ok) begin
          pend.push_back('{mPc, epoch});
          mPc = mPc + 32'd4;
        end
        if (redirect) begin
          epoch++;
          mq.delete();
          mPc = redirect_pc;
          mHalt = redirect_pc[1:0] != 2'b00;
          if (mHalt) mq.push_back('{redirect_pc, 32'h0, 1'b1});
        end
      end
      advance();
    end
    $display("random run done: epochs=%0d", epoch);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
